// File: rtl/sisc_pkg.sv
// ---------------------------------------------------------------------------
// sisc_pkg
// Shared definitions for the SISC core front end: default instruction word
// and address widths, the default prefetch queue depth, the prefetch FSM
// state encoding, and a saturating 16-bit increment helper used by the
// optional performance counters (IFQ_PERF_EN).
// No ports; imported by ifq_fifo and ifetch_q.
// ---------------------------------------------------------------------------
package sisc_pkg;

  localparam int IFQ_DW    = 32;
  localparam int IFQ_AW    = 16;
  localparam int IFQ_DEPTH = 4;

  typedef enum logic [1:0] {
    IFQ_FETCH = 2'd0,
    IFQ_FULL  = 2'd1,
    IFQ_HALT  = 2'd2
  } ifq_state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ifetch_q_if.sv
// ---------------------------------------------------------------------------
// ifetch_q_if
// Bundle of the prefetch queue's memory-side, IR-side and redirect signals.
//   memory side : mem_req, mem_addr (queue -> memory), mem_ack, mem_data
//   IR side     : ir_load (consumer pop), instr_out, instr_pc, instr_valid,
//                 count (occupancy)
//   control     : br_taken, br_addr (flush + redirect), halt
// Modports:
//   master - used by ifetch_q (drives requests and head outputs)
//   slave  - used by the memory / IR / branch environment
// ---------------------------------------------------------------------------
interface ifetch_q_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 32
) ();

  logic                       mem_req;
  logic [AW-1:0]              mem_addr;
  logic                       mem_ack;
  logic [DW-1:0]              mem_data;
  logic                       ir_load;
  logic [DW-1:0]              instr_out;
  logic [AW-1:0]              instr_pc;
  logic                       instr_valid;
  logic                       br_taken;
  logic [AW-1:0]              br_addr;
  logic                       halt;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output mem_req, mem_addr, instr_out, instr_pc, instr_valid, count,
    input  mem_ack, mem_data, ir_load, br_taken, br_addr, halt
  );

  modport slave (
    input  mem_req, mem_addr, instr_out, instr_pc, instr_valid, count,
    output mem_ack, mem_data, ir_load, br_taken, br_addr, halt
  );

endinterface

// File: rtl/ifq_fifo.sv
// ---------------------------------------------------------------------------
// ifq_fifo
// DEPTH-entry storage for fetched {word, pc} pairs with read/write pointers
// and an occupancy count. DEPTH must be a power of two so the pointers wrap
// naturally.
// Ports:
//   clk, rst_f  - clock, synchronous active-high reset
//   clear_i     - flush: empties the queue, takes priority over push/pop
//   push_i      - write wdata_i at the write pointer (caller guarantees room)
//   pop_i       - retire the head entry (caller guarantees non-empty)
//   wdata_i     - entry to write
//   head_o      - oldest entry, forced to zero while empty
//   count_o     - current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ifq_fifo
  import sisc_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int W     = IFQ_DW + IFQ_AW
) (
  input  logic                   clk,
  input  logic                   rst_f,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Pointer and occupancy bookkeeping; a flush returns everything to the
  // reset position so the next word lands in entry 0.
  always_ff @(posedge clk) begin
    if (rst_f || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; stale contents are hidden by the
  // empty mask on the head output.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i && !rst_f) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_q.sv
// ---------------------------------------------------------------------------
// ifetch_q
// Instruction prefetch queue for the SISC core. Issues sequential fetch
// requests from the fetch PC, buffers returned words with their PC in an
// ifq_fifo, and presents the oldest word to the IR load path. A taken
// branch flushes the queue and redirects fetch; halt stops new requests
// while leaving queued words available.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_f  - synchronous active-high reset, overrides every other input
//   bus    - ifetch_q_if.master (memory handshake, IR head, branch, halt)
//   flush_cnt, stall_cnt - 16-bit saturating performance counters, present
//            only when the IFQ_PERF_EN macro is defined
// ---------------------------------------------------------------------------
module ifetch_q
  import sisc_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int AW    = IFQ_AW,
  parameter int DW    = IFQ_DW
) (
  input  logic        clk,
  input  logic        rst_f,
  ifetch_q_if.master  bus
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0] flush_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_e        state_q, state_d;
  logic [AW-1:0]     fpc_q, fpc_d;
  logic              push, pop;
  logic [CW-1:0]     count_cur, count_nxt;
  logic [DW+AW-1:0]  head;

  ifq_fifo #(.DEPTH(DEPTH), .W(DW + AW)) u_fifo (
    .clk     (clk),
    .rst_f   (rst_f),
    .clear_i (bus.br_taken),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.mem_data, fpc_q}),
    .head_o  (head),
    .count_o (count_cur)
  );

  // Requests are a pure function of state so mem_addr/mem_req stay stable
  // until acked; reset masks the request while it is held.
  assign bus.mem_req     = (state_q == IFQ_FETCH) && !rst_f;
  assign bus.mem_addr    = fpc_q;
  assign bus.instr_out   = head[DW+AW-1:AW];
  assign bus.instr_pc    = head[AW-1:0];
  assign bus.instr_valid = (count_cur != '0);
  assign bus.count       = count_cur;

  // A branch discards both a same-cycle transfer and a same-cycle pop.
  assign push = bus.mem_req && bus.mem_ack && !bus.br_taken;
  assign pop  = bus.ir_load && bus.instr_valid && !bus.br_taken;

  // Next-state logic. Full is decided on the post-update occupancy so that
  // the request drops the cycle after the last free slot is filled, and
  // rises again the cycle after a pop from a full queue.
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    count_nxt = count_cur;
    case ({push, pop})
      2'b10:   count_nxt = count_cur + CW'(1);
      2'b01:   count_nxt = count_cur - CW'(1);
      default: count_nxt = count_cur;
    endcase
    if (push) fpc_d = fpc_q + AW'(1);
    if (bus.br_taken) begin
      fpc_d   = bus.br_addr;
      state_d = bus.halt ? IFQ_HALT : IFQ_FETCH;
    end else if (bus.halt) begin
      state_d = IFQ_HALT;
    end else if (count_nxt == CW'(DEPTH)) begin
      state_d = IFQ_FULL;
    end else begin
      state_d = IFQ_FETCH;
    end
  end

  // FSM state and fetch PC registers.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q <= IFQ_FETCH;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
    end
  end

`ifdef IFQ_PERF_EN
  logic [15:0] flush_cnt_q;
  logic [15:0] stall_cnt_q;

  // Flushes and memory wait cycles, both saturating.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.br_taken)                  flush_cnt_q <= sat_inc16(flush_cnt_q);
      if (bus.mem_req && !bus.mem_ack)   stall_cnt_q <= sat_inc16(stall_cnt_q);
    end
  end

  assign flush_cnt = flush_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_q.sv
// ---------------------------------------------------------------------------
// tb_ifetch_q
// Directed bench for ifetch_q: fill to full, pop from full, memory stalls,
// branch flush with a colliding ack, fetch-address wrap, halt with pops and
// an ignored pop while empty, and reset overriding a branch. Performance
// counter checks are compiled in when IFQ_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_ifetch_q;

  logic clk;
  logic rst_f;
  int   testCount;
  int   failCount;

  ifetch_q_if #(.DEPTH(4), .AW(16), .DW(32)) ifqBus ();

`ifdef IFQ_PERF_EN
  logic [15:0] flushCnt;
  logic [15:0] stallCnt;
`endif

  ifetch_q #(.DEPTH(4), .AW(16), .DW(32)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (ifqBus)
`ifdef IFQ_PERF_EN
    ,
    .flush_cnt (flushCnt),
    .stall_cnt (stallCnt)
`endif
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic ack, input logic [31:0] data,
                               input logic load, input logic br,
                               input logic [15:0] brAddr, input logic hlt);
    ifqBus.mem_ack  = ack;
    ifqBus.mem_data = data;
    ifqBus.ir_load  = load;
    ifqBus.br_taken = br;
    ifqBus.br_addr  = brAddr;
    ifqBus.halt     = hlt;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and sample well clear of it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Linear directed sequence; every expected value is worked out by hand.
  initial begin
    testCount = 0;
    failCount = 0;
    rst_f = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    tick();
    checkOutput("rst_mem_req",   {31'b0, ifqBus.mem_req},     32'h0);
    checkOutput("rst_count",     {29'b0, ifqBus.count},       32'h0);
    checkOutput("rst_valid",     {31'b0, ifqBus.instr_valid}, 32'h0);
    checkOutput("rst_instr_out", ifqBus.instr_out,            32'h0);
    checkOutput("rst_instr_pc",  {16'b0, ifqBus.instr_pc},    32'h0);
`ifdef IFQ_PERF_EN
    checkOutput("rst_flush_cnt", {16'b0, flushCnt}, 32'h0);
    checkOutput("rst_stall_cnt", {16'b0, stallCnt}, 32'h0);
`endif
    rst_f = 1'b0;
    #1;
    checkOutput("t1_first_req",  {31'b0, ifqBus.mem_req},  32'h1);
    checkOutput("t1_first_addr", {16'b0, ifqBus.mem_addr}, 32'h0);

    // Fill four entries from address 0 with ack held high.
    applyStimulus(1'b1, 32'hC0DE_0000, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t1_valid_lat",  {31'b0, ifqBus.instr_valid}, 32'h1);
    checkOutput("t1_count1",     {29'b0, ifqBus.count},       32'h1);
    checkOutput("t1_head_pc0",   {16'b0, ifqBus.instr_pc},    32'h0);
    checkOutput("t1_head_word0", ifqBus.instr_out,            32'hC0DE_0000);
    checkOutput("t1_addr1",      {16'b0, ifqBus.mem_addr},    32'h1);
    applyStimulus(1'b1, 32'hC0DE_0001, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t1_count2", {29'b0, ifqBus.count},    32'h2);
    checkOutput("t1_addr2",  {16'b0, ifqBus.mem_addr}, 32'h2);
    applyStimulus(1'b1, 32'hC0DE_0002, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t1_count3", {29'b0, ifqBus.count},    32'h3);
    checkOutput("t1_addr3",  {16'b0, ifqBus.mem_addr}, 32'h3);
    checkOutput("t1_req3",   {31'b0, ifqBus.mem_req},  32'h1);
    applyStimulus(1'b1, 32'hC0DE_0003, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t1_full_count", {29'b0, ifqBus.count},       32'h4);
    checkOutput("t1_full_req",   {31'b0, ifqBus.mem_req},     32'h0);
    checkOutput("t1_full_pc",    {16'b0, ifqBus.instr_pc},    32'h0);
    checkOutput("t1_full_valid", {31'b0, ifqBus.instr_valid}, 32'h1);
    checkOutput("t1_full_word",  ifqBus.instr_out,            32'hC0DE_0000);

    // Pop from full; ack stays high but nothing may be written.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t2_count", {29'b0, ifqBus.count},    32'h3);
    checkOutput("t2_pc",    {16'b0, ifqBus.instr_pc}, 32'h1);
    checkOutput("t2_word",  ifqBus.instr_out,         32'hC0DE_0001);
    checkOutput("t2_req",   {31'b0, ifqBus.mem_req},  32'h1);
    checkOutput("t2_addr",  {16'b0, ifqBus.mem_addr}, 32'h4);
    applyStimulus(1'b1, 32'hC0DE_0004, 1'b1, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t2_pushpop_count", {29'b0, ifqBus.count},    32'h3);
    checkOutput("t2_pushpop_pc",    {16'b0, ifqBus.instr_pc}, 32'h2);
    checkOutput("t2_pushpop_addr",  {16'b0, ifqBus.mem_addr}, 32'h5);

    // Three wait cycles at fpc=5.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t3_stall_req",   {31'b0, ifqBus.mem_req},  32'h1);
      checkOutput("t3_stall_addr",  {16'b0, ifqBus.mem_addr}, 32'h5);
      checkOutput("t3_stall_count", {29'b0, ifqBus.count},    32'h3);
    end
`ifdef IFQ_PERF_EN
    checkOutput("t3_stall_cnt", {16'b0, stallCnt}, 32'h3);
`endif

    // Advance fpc to 7, then branch with a colliding ack and pop.
    applyStimulus(1'b1, 32'hC0DE_0005, 1'b1, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t4_pre_pc", {16'b0, ifqBus.instr_pc}, 32'h3);
    applyStimulus(1'b1, 32'hC0DE_0006, 1'b1, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t4_pre_addr", {16'b0, ifqBus.mem_addr}, 32'h7);
    applyStimulus(1'b1, 32'hC0DE_0007, 1'b1, 1'b1, 16'h0040, 1'b0);
    tick();
    checkOutput("t4_flush_valid", {31'b0, ifqBus.instr_valid}, 32'h0);
    checkOutput("t4_flush_count", {29'b0, ifqBus.count},       32'h0);
    checkOutput("t4_flush_addr",  {16'b0, ifqBus.mem_addr},    32'h40);
    checkOutput("t4_flush_req",   {31'b0, ifqBus.mem_req},     32'h1);
    checkOutput("t4_flush_word",  ifqBus.instr_out,            32'h0);
`ifdef IFQ_PERF_EN
    checkOutput("t4_flush_cnt", {16'b0, flushCnt}, 32'h1);
`endif
    applyStimulus(1'b1, 32'hC0DE_0040, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t4_head_pc",   {16'b0, ifqBus.instr_pc}, 32'h40);
    checkOutput("t4_head_word", ifqBus.instr_out,         32'hC0DE_0040);
    checkOutput("t4_count",     {29'b0, ifqBus.count},    32'h1);

    // Redirect to 0xFFFE and fetch across the address wrap.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    tick();
    checkOutput("t5_addr_fffe", {16'b0, ifqBus.mem_addr}, 32'hFFFE);
    checkOutput("t5_count0",    {29'b0, ifqBus.count},    32'h0);
    applyStimulus(1'b1, 32'hC0DE_FFFE, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t5_addr_ffff", {16'b0, ifqBus.mem_addr}, 32'hFFFF);
    checkOutput("t5_pc_fffe",   {16'b0, ifqBus.instr_pc}, 32'hFFFE);
    applyStimulus(1'b1, 32'hC0DE_FFFF, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t5_addr_wrap", {16'b0, ifqBus.mem_addr}, 32'h0);
    applyStimulus(1'b1, 32'hC0DE_0000, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t5_addr_0001", {16'b0, ifqBus.mem_addr}, 32'h1);
    checkOutput("t5_count3",    {29'b0, ifqBus.count},    32'h3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t5_pc_ffff",   {16'b0, ifqBus.instr_pc}, 32'hFFFF);
    checkOutput("t5_word_ffff", ifqBus.instr_out,         32'hC0DE_FFFF);
    checkOutput("t5_count2",    {29'b0, ifqBus.count},    32'h2);
`ifdef IFQ_PERF_EN
    checkOutput("t5_stall_cnt", {16'b0, stallCnt}, 32'h5);
    checkOutput("t5_flush_cnt", {16'b0, flushCnt}, 32'h2);
`endif

    // Halt with two queued entries and three pop attempts.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    tick();
    checkOutput("t6_req_halt1", {31'b0, ifqBus.mem_req},  32'h0);
    checkOutput("t6_count1",    {29'b0, ifqBus.count},    32'h1);
    checkOutput("t6_pc_wrap",   {16'b0, ifqBus.instr_pc}, 32'h0);
    tick();
    checkOutput("t6_req_halt2", {31'b0, ifqBus.mem_req},     32'h0);
    checkOutput("t6_count0",    {29'b0, ifqBus.count},       32'h0);
    checkOutput("t6_valid0",    {31'b0, ifqBus.instr_valid}, 32'h0);
    tick();
    checkOutput("t6_req_halt3",   {31'b0, ifqBus.mem_req}, 32'h0);
    checkOutput("t6_empty_count", {29'b0, ifqBus.count},   32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("t6_release_req",  {31'b0, ifqBus.mem_req},  32'h1);
    checkOutput("t6_release_addr", {16'b0, ifqBus.mem_addr}, 32'h1);
`ifdef IFQ_PERF_EN
    checkOutput("t6_stall_cnt", {16'b0, stallCnt}, 32'h6);
    checkOutput("t6_flush_cnt", {16'b0, flushCnt}, 32'h2);
`endif

    // Reset wins over a simultaneous branch and ack.
    applyStimulus(1'b1, 32'hDEAD_0001, 1'b0, 1'b1, 16'h1234, 1'b0);
    rst_f = 1'b1;
    tick();
    checkOutput("t7_rst_count", {29'b0, ifqBus.count},       32'h0);
    checkOutput("t7_rst_valid", {31'b0, ifqBus.instr_valid}, 32'h0);
    checkOutput("t7_rst_req",   {31'b0, ifqBus.mem_req},     32'h0);
`ifdef IFQ_PERF_EN
    checkOutput("t7_rst_flush_cnt", {16'b0, flushCnt}, 32'h0);
    checkOutput("t7_rst_stall_cnt", {16'b0, stallCnt}, 32'h0);
`endif
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    rst_f = 1'b0;
    #1;
    checkOutput("t7_post_addr", {16'b0, ifqBus.mem_addr}, 32'h0);
    checkOutput("t7_post_req",  {31'b0, ifqBus.mem_req},  32'h1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
